leaf_config_sequencer: RTL and testbench

Post-reset configuration engine for the BFT overlay. Reads a route table from an external synchronous ROM and emits one 49-bit config packet per entry into a BFT leaf port, programming each `leaf_interface` output-port destination (dest leaf, dest port). Holds the user logic in reset until every entry has been accepted by the network. Sits beside the leaf-only interface wrapper on a dedicated BFT leaf.

---
 rtl/bft_pkg.sv | 35 +++
 rtl/cfg_gap_counter.sv | 41 ++++
 rtl/leaf_config_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_leaf_config_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// Shared definitions for the BFT leaf configuration sequencer:
// packet field offsets, the config port, route-entry slices and FSM encoding.
package bft_pkg;

  // Config packet field positions
  localparam int PKT_VALID_BIT    = 48;
  localparam int PKT_TGT_LSB      = 44;
  localparam int PKT_PORT_LSB     = 40;
  localparam int PKT_IDX_LSB      = 33;
  localparam int PKT_IDX_BITS     = 7;
  localparam int PKT_CFG_BIT      = 32;
  localparam int PKT_OUT_IDX_LSB  = 28;
  localparam int PKT_DST_LEAF_LSB = 24;
  localparam int PKT_DST_PORT_LSB = 20;
  localparam int PKT_PAYLOAD_BITS = 32;

  // Config packets are always addressed to port 0 of the target leaf
  localparam logic [3:0] CFG_PORT = 4'd0;

  // Route-table entry slices: {tgt_leaf, out_idx, dst_leaf, dst_port}
  localparam int ENT_TGT_LSB      = 12;
  localparam int ENT_OUT_IDX_LSB  = 8;
  localparam int ENT_DST_LEAF_LSB = 4;
  localparam int ENT_DST_PORT_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } cfg_state_e;

endpackage

// File: rtl/cfg_gap_counter.sv
// Loadable down-counter with zero flag; paces the idle gap between packets.
module cfg_gap_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins over load, load wins over decrement; never underflows
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/leaf_config_sequencer.sv
// Post-reset configuration engine: walks the route-table ROM and sends one
// config packet per entry into a BFT leaf, holding user logic in reset until
// every packet has been accepted.
// Optional build macro LEAF_CFG_CHECKSUM_EN adds an XOR accumulator of the
// accepted payloads on cfg_checksum (tied to zero otherwise).
module leaf_config_sequencer
  import bft_pkg::*;
#(
  parameter int PACKET_BITS     = 49,
  parameter int NUM_LEAF_BITS   = 4,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_ENTRIES     = 16,
  parameter int TABLE_ADDR_BITS = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       resend,
  output logic                       tbl_rd_en,
  output logic [TABLE_ADDR_BITS-1:0] tbl_rd_addr,
  input  logic [15:0]                tbl_rd_data,
  output logic [PACKET_BITS-1:0]     dout_leaf_cfg2bft,
  input  logic                       bft_accept,
  output logic                       cfg_done,
  output logic                       user_reset_n,
  output logic [31:0]                cfg_checksum
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Loaded with GAP_CYCLES-1 so the GAP state lasts exactly GAP_CYCLES cycles
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [TABLE_ADDR_BITS-1:0] LAST_IDX = TABLE_ADDR_BITS'(NUM_ENTRIES - 1);

  cfg_state_e                 state_q, state_d;
  logic [TABLE_ADDR_BITS-1:0] idx_q, idx_d;
  logic                       rd_en_q, rd_en_d;
  logic [TABLE_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [PACKET_BITS-1:0]     pkt_q, pkt_d;
  logic                       done_q, done_d;
  logic                       ureset_q, ureset_d;
  logic [PACKET_BITS-1:0]     load_pkt_s;
  logic                       gap_clr_s, gap_load_s, gap_dec_s, gap_zero_s;

  cfg_gap_counter #(.WIDTH(GAP_W)) u_gap (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (gap_clr_s),
    .load     (gap_load_s),
    .load_val (GAP_LOAD),
    .dec      (gap_dec_s),
    .zero     (gap_zero_s)
  );

  // Assemble the config packet from the ROM word returned for the current index
  always_comb begin
    load_pkt_s = '0;
    load_pkt_s[PKT_VALID_BIT] = 1'b1;
    load_pkt_s[PKT_TGT_LSB +: NUM_LEAF_BITS]      = tbl_rd_data[ENT_TGT_LSB +: NUM_LEAF_BITS];
    load_pkt_s[PKT_PORT_LSB +: NUM_PORT_BITS]     = NUM_PORT_BITS'(CFG_PORT);
    load_pkt_s[PKT_IDX_LSB +: PKT_IDX_BITS]       = PKT_IDX_BITS'(idx_q);
    load_pkt_s[PKT_CFG_BIT] = 1'b1;
    load_pkt_s[PKT_OUT_IDX_LSB +: NUM_PORT_BITS]  = tbl_rd_data[ENT_OUT_IDX_LSB +: NUM_PORT_BITS];
    load_pkt_s[PKT_DST_LEAF_LSB +: NUM_LEAF_BITS] = tbl_rd_data[ENT_DST_LEAF_LSB +: NUM_LEAF_BITS];
    load_pkt_s[PKT_DST_PORT_LSB +: NUM_PORT_BITS] = tbl_rd_data[ENT_DST_PORT_LSB +: NUM_PORT_BITS];
  end

  // Sequencer next-state and next-output logic; resend overrides every state
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    pkt_d      = pkt_q;
    done_d     = done_q;
    ureset_d   = ureset_q;
    gap_clr_s  = 1'b0;
    gap_load_s = 1'b0;
    gap_dec_s  = 1'b0;
    if (resend) begin
      state_d   = ST_READ;
      idx_d     = '0;
      rd_en_d   = 1'b1;
      rd_addr_d = '0;
      pkt_d     = '0;
      done_d    = 1'b0;
      ureset_d  = 1'b0;
      gap_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          rd_addr_d = idx_q;
        end
        ST_READ: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          pkt_d   = load_pkt_s;
          state_d = ST_SEND;
        end
        ST_SEND: begin
          if (bft_accept) begin
            pkt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              ureset_d = 1'b1;
            end else if (GAP_CYCLES == 0) begin
              idx_d     = idx_q + TABLE_ADDR_BITS'(1);
              state_d   = ST_READ;
              rd_en_d   = 1'b1;
              rd_addr_d = idx_q + TABLE_ADDR_BITS'(1);
            end else begin
              idx_d      = idx_q + TABLE_ADDR_BITS'(1);
              state_d    = ST_GAP;
              gap_load_s = 1'b1;
            end
          end else begin
            state_d = ST_SEND;
          end
        end
        ST_GAP: begin
          if (gap_zero_s) begin
            state_d   = ST_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q;
          end else begin
            gap_dec_s = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      pkt_q     <= '0;
      done_q    <= 1'b0;
      ureset_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      pkt_q     <= pkt_d;
      done_q    <= done_d;
      ureset_q  <= ureset_d;
    end
  end

  assign tbl_rd_en         = rd_en_q;
  assign tbl_rd_addr       = rd_addr_q;
  assign dout_leaf_cfg2bft = pkt_q;
  assign cfg_done          = done_q;
  assign user_reset_n      = ureset_q;

`ifdef LEAF_CFG_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Fold each accepted payload into the running XOR; resend restarts it
  always_comb begin
    if (resend) begin
      csum_d = 32'd0;
    end else if ((state_q == ST_SEND) && bft_accept) begin
      csum_d = csum_q ^ pkt_q[PKT_PAYLOAD_BITS-1:0];
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= 32'd0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign cfg_checksum = csum_q;
`else
  assign cfg_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_leaf_config_sequencer.sv
// Self-checking bench for leaf_config_sequencer: table-driven basic sequence,
// hand-written corner cases and a randomized run against a transaction model.
module tb_leaf_config_sequencer;

  localparam int N_A = 3;
  localparam int G_A = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 3 entries, gap 2
  logic        resend_a, acc_a, rd_en_a, done_a, urst_a;
  logic [3:0]  addr_a;
  logic [15:0] data_a;
  logic [48:0] pkt_a;
  logic [31:0] cs_a;
  logic [15:0] rom_a [16];

  // DUT B: 1 entry, no gap
  logic        resend_b, acc_b, rd_en_b, done_b, urst_b;
  logic [3:0]  addr_b;
  logic [15:0] data_b;
  logic [48:0] pkt_b;
  logic [31:0] cs_b;
  logic [15:0] rom_b;

  leaf_config_sequencer #(.NUM_ENTRIES(N_A), .GAP_CYCLES(G_A)) dut (
    .clk(clk), .reset_n(reset_n), .resend(resend_a),
    .tbl_rd_en(rd_en_a), .tbl_rd_addr(addr_a), .tbl_rd_data(data_a),
    .dout_leaf_cfg2bft(pkt_a), .bft_accept(acc_a),
    .cfg_done(done_a), .user_reset_n(urst_a), .cfg_checksum(cs_a)
  );

  leaf_config_sequencer #(.NUM_ENTRIES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .resend(resend_b),
    .tbl_rd_en(rd_en_b), .tbl_rd_addr(addr_b), .tbl_rd_data(data_b),
    .dout_leaf_cfg2bft(pkt_b), .bft_accept(acc_b),
    .cfg_done(done_b), .user_reset_n(urst_b), .cfg_checksum(cs_b)
  );

  // Synchronous ROMs: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en_a) data_a <= rom_a[addr_a];
    if (rd_en_b) data_b <= rom_b;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference packet built straight from the documented field layout
  function automatic logic [48:0] ref_pkt(input logic [15:0] e, input int idx);
    logic [48:0] p;
    p = (49'd1 << 48) | (49'(e[15:12]) << 44) | (49'(idx) << 33)
      | (49'd1 << 32) | (49'(e[11:0]) << 20);
    return p;
  endfunction

  function automatic logic [31:0] exp_cs(input logic [31:0] x);
`ifdef LEAF_CFG_CHECKSUM_EN
    return x;
`else
    return 32'd0 & x;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    edge_n++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    acc_a = 1'b0; resend_a = 1'b0;
    acc_b = 1'b0; resend_b = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic wait_valid_a();
    for (int k = 0; k < 40; k++) begin
      if (pkt_a[48]) break;
      step();
    end
    check("valid_seen", 64'(pkt_a[48]), 64'd1);
  endtask

  typedef struct {
    logic [15:0] word;
    logic [48:0] pkt;
    int          edge_at;
  } vec_t;
  vec_t vecs [3];

  initial begin
    logic [31:0] csx;
    logic [48:0] p0;
    logic [48:0] rp;
    int          exp_idx, nve;
    logic        waiting, done_e, exp_v;
    logic [31:0] cs_e;

    vecs[0] = '{16'h1234, 49'h1_1001_2340_0000, 3};
    vecs[1] = '{16'h2345, 49'h1_2003_3450_0000, 8};
    vecs[2] = '{16'h3456, 49'h1_3005_4560_0000, 13};
    for (int i = 0; i < 16; i++) rom_a[i] = 16'd0;
    for (int i = 0; i < 3; i++) rom_a[i] = vecs[i].word;
    rom_b = 16'h1234;
    acc_a = 1'b0; resend_a = 1'b0; acc_b = 1'b0; resend_b = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_pkt", 64'(pkt_a), 64'd0);
    check("rst_rd_en", 64'(rd_en_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_urst", 64'(urst_a), 64'd0);
    check("rst_cs", 64'(cs_a), 64'd0);

    // Basic sequence, accept tied high, table driven
    do_reset();
    acc_a = 1'b1;
    step();
    check("basic_rd_en_e1", 64'(rd_en_a), 64'd1);
    check("basic_addr_e1", 64'(addr_a), 64'd0);
    csx = 32'd0;
    for (int i = 0; i < 3; i++) begin
      wait_valid_a();
      check("basic_edge", 64'(edge_n), 64'(vecs[i].edge_at));
      check("basic_pkt", 64'(pkt_a), 64'(vecs[i].pkt));
      check("basic_done_early", 64'(done_a), 64'd0);
      csx = csx ^ vecs[i].pkt[31:0];
      step();
      check("basic_valid_drop", 64'(pkt_a[48]), 64'd0);
    end
    check("basic_done_edge", 64'(edge_n), 64'd14);
    check("basic_done", 64'(done_a), 64'd1);
    check("basic_urst", 64'(urst_a), 64'd1);
    check("basic_cs", 64'(cs_a), 64'(exp_cs(csx)));

    // Backpressure: 10 stalled cycles, then accept
    do_reset();
    wait_valid_a();
    p0 = pkt_a;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_stable", 64'(pkt_a), 64'(p0));
      check("bp_rd_en_low", 64'(rd_en_a), 64'd0);
    end
    acc_a = 1'b1;
    step();
    acc_a = 1'b0;
    check("bp_valid_drop", 64'(pkt_a[48]), 64'd0);
    step();
    check("bp_gap_rd_en", 64'(rd_en_a), 64'd0);
    step();
    check("bp_next_rd_en", 64'(rd_en_a), 64'd1);
    check("bp_next_addr", 64'(addr_a), 64'd1);
    step(); step();
    check("bp_next_pkt", 64'(pkt_a), 64'(ref_pkt(rom_a[1], 1)));

    // Resend while at entry 1 in GAP
    do_reset();
    acc_a = 1'b1;
    repeat (9) step();
    resend_a = 1'b1;
    step();
    resend_a = 1'b0;
    check("rs_valid", 64'(pkt_a[48]), 64'd0);
    check("rs_done", 64'(done_a), 64'd0);
    check("rs_urst", 64'(urst_a), 64'd0);
    check("rs_rd_en", 64'(rd_en_a), 64'd1);
    check("rs_addr", 64'(addr_a), 64'd0);
    step(); step();
    check("rs_pkt0", 64'(pkt_a), 64'(ref_pkt(rom_a[0], 0)));

    // Asynchronous reset mid-SEND
    do_reset();
    wait_valid_a();
    #2 reset_n = 1'b0;
    #1;
    check("ar_pkt", 64'(pkt_a), 64'd0);
    check("ar_rd_en", 64'(rd_en_a), 64'd0);
    check("ar_addr", 64'(addr_a), 64'd0);
    check("ar_done", 64'(done_a), 64'd0);
    check("ar_urst", 64'(urst_a), 64'd0);
    check("ar_cs", 64'(cs_a), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    edge_n = 0;
    step(); step();
    check("ar_valid_e2", 64'(pkt_a[48]), 64'd0);
    step();
    check("ar_pkt_e3", 64'(pkt_a), 64'(ref_pkt(rom_a[0], 0)));

    // Zero gap, single entry
    do_reset();
    acc_b = 1'b1;
    repeat (3) step();
    check("zg_pkt_e3", 64'(pkt_b), 64'(ref_pkt(rom_b, 0)));
    check("zg_done_e3", 64'(done_b), 64'd0);
    step();
    check("zg_done_e4", 64'(done_b), 64'd1);
    check("zg_urst_e4", 64'(urst_b), 64'd1);
    check("zg_cs", 64'(cs_b), 64'(exp_cs(32'h2340_0000)));

    // Randomized run against a transaction-level model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N_A; i++) rom_a[i] = 16'($urandom);
      do_reset();
      exp_idx = 0; cs_e = 32'd0; done_e = 1'b0; waiting = 1'b1; nve = 3;
      for (int c = 0; c < 150; c++) begin
        exp_v = waiting && (edge_n >= nve);
        resend_a = ($urandom_range(0, 59) == 0);
        acc_a = ($urandom_range(0, 2) != 0);
        step();
        if (resend_a) begin
          exp_idx = 0; cs_e = 32'd0; done_e = 1'b0; waiting = 1'b1; nve = edge_n + 2;
        end else if (exp_v && acc_a) begin
          rp = ref_pkt(rom_a[exp_idx], exp_idx);
          cs_e = cs_e ^ rp[31:0];
          waiting = 1'b0;
          if (exp_idx == N_A - 1) begin
            done_e = 1'b1;
          end else begin
            exp_idx++;
            waiting = 1'b1;
            nve = edge_n + 2 + G_A;
          end
        end
        exp_v = waiting && (edge_n >= nve);
        check("rnd_valid", 64'(pkt_a[48]), 64'(exp_v));
        if (exp_v) check("rnd_pkt", 64'(pkt_a), 64'(ref_pkt(rom_a[exp_idx], exp_idx)));
        check("rnd_rd_en", 64'(rd_en_a), 64'(waiting && (edge_n == nve - 2)));
        if (rd_en_a) check("rnd_addr", 64'(addr_a), 64'(exp_idx));
        check("rnd_done", 64'(done_a), 64'(done_e));
        check("rnd_urst", 64'(urst_a), 64'(done_e));
        check("rnd_cs", 64'(cs_a), 64'(exp_cs(cs_e)));
      end
      resend_a = 1'b0;
      acc_a = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
